// File: rtl/scan_sequencer.sv
// Channel scan sequencer: steps a 3-bit decoder select across enabled channels with a programmable dwell.
// Optional SCAN_MASK_EN adds an 8-bit channel mask; without it all eight channels are scanned.
module scan_sequencer #(
    parameter int DWELL_W = 4
) (
    input  logic               clka,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [DWELL_W-1:0] dwell,
`ifdef SCAN_MASK_EN
    input  logic [7:0]         mask,
`endif
    output logic               E,
    output logic [2:0]         In,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic               e_r;
    logic [2:0]         in_r;
    logic               busy_r;
    logic               done_r;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_l;
    logic               cont_l;
    logic [7:0]         mask_l;
    logic [7:0]         start_mask;

`ifdef SCAN_MASK_EN
    assign start_mask = mask;
`else
    assign start_mask = 8'hFF;
`endif

    function automatic logic [2:0] lowest_ch(input logic [7:0] m);
        lowest_ch = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) lowest_ch = 3'(i);
        end
    endfunction

    function automatic logic [2:0] next_ch(input logic [7:0] m, input logic [2:0] cur);
        next_ch = cur;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) next_ch = 3'(i);
        end
    endfunction

    function automatic logic is_last(input logic [7:0] m, input logic [2:0] cur);
        is_last = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (m[i] && (i > int'(cur))) is_last = 1'b0;
        end
    endfunction

    always_ff @(posedge clka) begin
        if (rst) begin
            state   <= IDLE;
            e_r     <= 1'b0;
            in_r    <= 3'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cnt     <= '0;
            dwell_l <= '0;
            cont_l  <= 1'b0;
            mask_l  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    e_r    <= 1'b0;
                    in_r   <= 3'd0;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    cnt    <= '0;
                    // An all-zero mask has nothing to scan, so the start is dropped
                    if (start && !stop && (start_mask != 8'h00)) begin
                        state   <= SCAN;
                        dwell_l <= dwell;
                        cont_l  <= cont;
                        mask_l  <= start_mask;
                        in_r    <= lowest_ch(start_mask);
                        e_r     <= 1'b1;
                        busy_r  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (stop) begin
                        state  <= IDLE;
                        e_r    <= 1'b0;
                        in_r   <= 3'd0;
                        busy_r <= 1'b0;
                        cnt    <= '0;
                    end else if (cnt == dwell_l) begin
                        cnt <= '0;
                        if (!is_last(mask_l, in_r)) begin
                            in_r <= next_ch(mask_l, in_r);
                        end else if (cont_l) begin
                            in_r <= lowest_ch(mask_l);
                        end else begin
                            state  <= DONE;
                            e_r    <= 1'b0;
                            in_r   <= 3'd0;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + DWELL_W'(1);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_r <= 1'b0;
                    e_r    <= 1'b0;
                    in_r   <= 3'd0;
                    busy_r <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    e_r    <= 1'b0;
                    in_r   <= 3'd0;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    cnt    <= '0;
                end
            endcase
        end
    end

    assign E    = e_r;
    assign In   = in_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer: expected {E,In,busy,done} per active cycle is queued by the
// stimulus and popped by a monitor whenever busy or done is high.
module tb_scan_sequencer;
    localparam int DWELL_W = 4;

    logic               clka = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               cont = 1'b0;
    logic [DWELL_W-1:0] dwell = '0;
`ifdef SCAN_MASK_EN
    logic [7:0]         mask = 8'h00;
`endif
    logic               E;
    logic [2:0]         In;
    logic               busy;
    logic               done;

    int errors = 0;
    int checks = 0;
    logic [5:0] exp_q[$];

    scan_sequencer #(.DWELL_W(DWELL_W)) dut (
        .clka  (clka),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .cont  (cont),
        .dwell (dwell),
`ifdef SCAN_MASK_EN
        .mask  (mask),
`endif
        .E     (E),
        .In    (In),
        .busy  (busy),
        .done  (done)
    );

    always #5 clka = ~clka;

    // Monitor: every active output cycle must match the head of the expected queue
    initial begin
        logic [5:0] exp_v;
        forever begin
            @(negedge clka);
            if (busy === 1'b1 || done === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got E=%0b In=%0d busy=%0b done=%0b required no active output",
                             E, In, busy, done);
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({E, In, busy, done} !== exp_v)
                        $display("FAIL scan_cycle got E=%0b In=%0d busy=%0b done=%0b required E=%0b In=%0d busy=%0b done=%0b",
                                 E, In, busy, done, exp_v[5], exp_v[4:2], exp_v[1], exp_v[0]);
                    if ({E, In, busy, done} !== exp_v) errors++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_ch(input logic [2:0] ch, input int reps);
        for (int r = 0; r < reps; r++) exp_q.push_back({1'b1, ch, 1'b1, 1'b0});
    endtask

    task automatic push_scan(input logic [7:0] m, input int dw, input bit with_done);
        for (int c = 0; c < 8; c++)
            if (m[c]) push_ch(3'(c), dw + 1);
        if (with_done) exp_q.push_back(6'b0_000_01);
    endtask

    task automatic start_scan(input logic [DWELL_W-1:0] d, input logic c, input logic [7:0] m);
        @(posedge clka);
        #1;
        start = 1'b1;
        dwell = d;
        cont  = c;
`ifdef SCAN_MASK_EN
        mask  = m;
`else
        if (m != 8'hFF) $display("note: mask argument unused in this build");
`endif
        @(posedge clka);
        #1;
        start = 1'b0;
    endtask

    task automatic check_idle(input string name);
        @(negedge clka);
        checks++;
        if ({E, In, busy, done} !== 6'b0) begin
            errors++;
            $display("FAIL %s got E=%0b In=%0d busy=%0b done=%0b required all zero", name, E, In, busy, done);
        end
    endtask

    task automatic wait_drain(input string name, input int maxc);
        for (int i = 0; i < maxc && exp_q.size() != 0; i++) @(posedge clka);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s got %0d outputs still pending required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        repeat (2) @(posedge clka);
        #1;
        rst = 1'b0;
        check_idle("reset_state");

        // Full sweep, one cycle per channel
        push_scan(8'hFF, 0, 1'b1);
        start_scan(4'd0, 1'b0, 8'hFF);
        wait_drain("sweep_dwell0", 40);
        check_idle("sweep_dwell0_idle");

        // Three cycles per channel; inputs changed mid-scan must not matter
        push_scan(8'hFF, 2, 1'b1);
        start_scan(4'd2, 1'b0, 8'hFF);
        dwell = 4'd0;
        cont  = 1'b1;
        wait_drain("sweep_dwell2", 60);
        check_idle("sweep_dwell2_idle");

        // Continuous wrap, stopped while In=3 on the second pass
        push_scan(8'hFF, 0, 1'b0);
        push_scan(8'h0F, 0, 1'b0);
        start_scan(4'd0, 1'b1, 8'hFF);
        repeat (11) @(posedge clka);
        #1;
        stop = 1'b1;
        @(posedge clka);
        #1;
        stop = 1'b0;
        cont = 1'b0;
        check_idle("stop_abort");
        wait_drain("stop_seq", 1);
        repeat (3) check_idle("stop_no_done");

        // Reset while In=4
        push_scan(8'h1F, 0, 1'b0);
        start_scan(4'd0, 1'b0, 8'hFF);
        repeat (4) @(posedge clka);
        #1;
        rst = 1'b1;
        @(posedge clka);
        #1;
        rst = 1'b0;
        check_idle("reset_mid_scan");
        wait_drain("reset_mid_seq", 1);

        // start and stop together in IDLE
        @(posedge clka);
        #1;
        start = 1'b1;
        stop  = 1'b1;
        repeat (3) check_idle("start_stop_idle");
        @(posedge clka);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        check_idle("start_stop_after");

        // start held through DONE relaunches after one IDLE cycle
        push_scan(8'hFF, 0, 1'b1);
        push_scan(8'hFF, 0, 1'b1);
        @(posedge clka);
        #1;
        start = 1'b1;
        dwell = 4'd0;
        cont  = 1'b0;
        @(posedge clka);
        repeat (9) @(posedge clka);
        check_idle("relaunch_gap");
        @(posedge clka);
        #1;
        start = 1'b0;
        wait_drain("relaunch", 40);
        check_idle("relaunch_idle");

`ifdef SCAN_MASK_EN
        // Masked channels are skipped
        exp_q.push_back({1'b1, 3'd2, 1'b1, 1'b0});
        exp_q.push_back({1'b1, 3'd2, 1'b1, 1'b0});
        exp_q.push_back({1'b1, 3'd5, 1'b1, 1'b0});
        exp_q.push_back({1'b1, 3'd5, 1'b1, 1'b0});
        exp_q.push_back({1'b1, 3'd7, 1'b1, 1'b0});
        exp_q.push_back({1'b1, 3'd7, 1'b1, 1'b0});
        exp_q.push_back(6'b0_000_01);
        start_scan(4'd1, 1'b0, 8'b1010_0100);
        wait_drain("mask_seq", 30);
        check_idle("mask_idle");

        // Empty mask: start ignored
        @(posedge clka);
        #1;
        mask  = 8'h00;
        start = 1'b1;
        repeat (3) check_idle("mask_zero");
        @(posedge clka);
        #1;
        start = 1'b0;
`endif

        repeat (3) @(posedge clka);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
